// File: rtl/weight_wr.sv
// Packs 24-bit weight triples from four kernels into a little-endian 32-bit word
// stream per kernel, written in lock-step to four BRAMs that share one address.
module weight_wr #(
    parameter int MEM_DATA_WIDTH = 32,
    parameter int MEM_ADDR_WIDTH = 32,
    parameter int BIT_WIDTH      = 8,
    parameter int NUM_CHANNEL    = 3,
    parameter int NUM_KERNEL     = 4,
    parameter int REG_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [MEM_ADDR_WIDTH-1:0] i_base_addr,
    input  logic [95:0]               i_dat,
    input  logic                      i_vld,
    output logic                      o_rdy,
    input  logic                      i_flush,
    output logic                      o_done,
    output logic [REG_WIDTH-1:0]      o_wcnt,
    output logic [MEM_ADDR_WIDTH-1:0] memx_addr,
    output logic                      memx_wren,
    output logic [MEM_DATA_WIDTH-1:0] mem0_idat,
    output logic [MEM_DATA_WIDTH-1:0] mem1_idat,
    output logic [MEM_DATA_WIDTH-1:0] mem2_idat,
    output logic [MEM_DATA_WIDTH-1:0] mem3_idat
);

    localparam int TRIPLE_W = NUM_CHANNEL * BIT_WIDTH;
    localparam int PAD_W    = MEM_DATA_WIDTH - TRIPLE_W;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    localparam logic [REG_WIDTH-1:0]      WCNT_ONE = REG_WIDTH'(1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = MEM_ADDR_WIDTH'(1);

    logic [0:0]                state;
    logic [1:0]                phase;
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic                      done_pend;
    logic [TRIPLE_W-1:0]       res      [NUM_KERNEL];
    logic [TRIPLE_W-1:0]       res_d    [NUM_KERNEL];
    logic [TRIPLE_W-1:0]       trip     [NUM_KERNEL];
    logic [MEM_DATA_WIDTH-1:0] word_d   [NUM_KERNEL];
    logic [MEM_DATA_WIDTH-1:0] word_q   [NUM_KERNEL];

    assign o_rdy     = (state == ST_RUN);
    assign mem0_idat = word_q[0];
    assign mem1_idat = word_q[1];
    assign mem2_idat = word_q[2];
    assign mem3_idat = word_q[3];

    // Residual bytes sit right-aligned in res with zero upper bytes, so a
    // flush simply zero-extends res into a word.
    always_comb begin
        for (int k = 0; k < NUM_KERNEL; k++) begin
            // NOTE: every comb output gets a default first so no path infers a latch.
            trip[k]   = i_dat[k*TRIPLE_W +: TRIPLE_W];
            word_d[k] = '0;
            res_d[k]  = trip[k];
            case (phase)
                2'd1: begin
                    word_d[k] = {trip[k][7:0], res[k][23:0]};
                    res_d[k]  = {8'h00, trip[k][23:8]};
                end
                2'd2: begin
                    word_d[k] = {trip[k][15:0], res[k][15:0]};
                    res_d[k]  = {16'h0000, trip[k][23:16]};
                end
                2'd3: begin
                    word_d[k] = {trip[k][23:0], res[k][7:0]};
                    res_d[k]  = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the residual and data arrays are a handful of flops, not a RAM, so they are reset.
            state     <= ST_RUN;
            phase     <= 2'd0;
            addr      <= '0;
            done_pend <= 1'b0;
            o_done    <= 1'b0;
            o_wcnt    <= '0;
            memx_addr <= '0;
            memx_wren <= 1'b0;
            for (int k = 0; k < NUM_KERNEL; k++) begin
                res[k]    <= '0;
                word_q[k] <= '0;
            end
        end else begin
            // NOTE: all state uses non-blocking assignment so every branch sees pre-edge values.
            memx_wren <= 1'b0;
            done_pend <= 1'b0;
            o_done    <= done_pend;
            if (i_start) begin
                state  <= ST_RUN;
                phase  <= 2'd0;
                addr   <= i_base_addr;
                o_wcnt <= '0;
                o_done <= 1'b0;
                for (int k = 0; k < NUM_KERNEL; k++) res[k] <= '0;
            end else if (state == ST_RUN) begin
                if (i_vld) begin
                    phase <= phase + 2'd1;
                    for (int k = 0; k < NUM_KERNEL; k++) res[k] <= res_d[k];
                    if (phase != 2'd0) begin
                        for (int k = 0; k < NUM_KERNEL; k++) word_q[k] <= word_d[k];
                        memx_wren <= 1'b1;
                        memx_addr <= addr;
                        addr      <= addr + ADDR_ONE;
                        o_wcnt    <= o_wcnt + WCNT_ONE;
                    end
                end
                if (i_flush) state <= ST_FLUSH;
            end else begin
                // Flush: emit the partial word if any bytes are pending.
                if (phase != 2'd0) begin
                    for (int k = 0; k < NUM_KERNEL; k++) word_q[k] <= {{PAD_W{1'b0}}, res[k]};
                    memx_wren <= 1'b1;
                    memx_addr <= addr;
                    addr      <= addr + ADDR_ONE;
                    o_wcnt    <= o_wcnt + WCNT_ONE;
                end
                phase     <= 2'd0;
                state     <= ST_RUN;
                done_pend <= 1'b1;
                for (int k = 0; k < NUM_KERNEL; k++) res[k] <= '0;
            end
        end
    end

endmodule

// File: tb/tb_weight_wr.sv
// Directed testbench for weight_wr: packing, flush, start-abort and async reset.
module tb_weight_wr;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_base_addr;
    logic [95:0] i_dat;
    logic        i_vld;
    logic        o_rdy;
    logic        i_flush;
    logic        o_done;
    logic [31:0] o_wcnt;
    logic [31:0] memx_addr;
    logic        memx_wren;
    logic [31:0] mem0_idat, mem1_idat, mem2_idat, mem3_idat;

    int n_cmp;
    int n_bad;

    weight_wr dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base_addr(i_base_addr),
        .i_dat(i_dat), .i_vld(i_vld), .o_rdy(o_rdy), .i_flush(i_flush),
        .o_done(o_done), .o_wcnt(o_wcnt), .memx_addr(memx_addr), .memx_wren(memx_wren),
        .mem0_idat(mem0_idat), .mem1_idat(mem1_idat), .mem2_idat(mem2_idat), .mem3_idat(mem3_idat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Kernel-0 triple n of the byte stream 0x01, 0x02, 0x03, ...; other kernels zero.
    function automatic logic [95:0] k0(input int n);
        logic [7:0] b0, b1, b2;
        b0 = 8'(3*n + 1);
        b1 = 8'(3*n + 2);
        b2 = 8'(3*n + 3);
        return {72'd0, b2, b1, b0};
    endfunction

    // Stream byte s of kernel k for the four-kernel scenario.
    function automatic logic [7:0] kb(input int k, input int s);
        return 8'(k*64 + s + 1);
    endfunction

    function automatic logic [95:0] all_trip(input int n);
        logic [95:0] d;
        d = '0;
        for (int k = 0; k < 4; k++)
            d[k*24 +: 24] = {kb(k, 3*n+2), kb(k, 3*n+1), kb(k, 3*n)};
        return d;
    endfunction

    function automatic logic [31:0] all_word(input int k, input int w);
        return {kb(k, 4*w+3), kb(k, 4*w+2), kb(k, 4*w+1), kb(k, 4*w)};
    endfunction

    task automatic feed(input logic [95:0] d);
        i_vld = 1'b1;
        i_dat = d;
        tick();
        i_vld = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] base);
        i_start     = 1'b1;
        i_base_addr = base;
        tick();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (memx_wren !== 1'b0) begin n_bad++; $display("FAIL reset_wren got %b exp 0", memx_wren); end
        n_cmp++; if (memx_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h exp 0", memx_addr); end
        n_cmp++; if (o_wcnt !== 32'h0) begin n_bad++; $display("FAIL reset_wcnt got %h exp 0", o_wcnt); end
        n_cmp++; if ({mem0_idat, mem1_idat, mem2_idat, mem3_idat} !== 128'h0) begin n_bad++; $display("FAIL reset_idat got %h %h %h %h exp 0", mem0_idat, mem1_idat, mem2_idat, mem3_idat); end
        n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b exp 0", o_done); end
        rst = 1'b0;
        tick();
        n_cmp++; if (o_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got %b exp 1", o_rdy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wexp [0:2];
        wexp = '{32'h04030201, 32'h08070605, 32'h0C0B0A09};
        do_start(32'h10);
        n_cmp++; if (o_wcnt !== 32'h0) begin n_bad++; $display("FAIL b2b_wcnt_start got %h exp 0", o_wcnt); end
        i_vld = 1'b1;
        for (int n = 0; n < 4; n++) begin
            i_dat = k0(n);
            tick();
            if (n == 0) begin
                n_cmp++; if (memx_wren !== 1'b0) begin n_bad++; $display("FAIL b2b_wren0 got %b exp 0", memx_wren); end
            end else begin
                n_cmp++; if (memx_wren !== 1'b1) begin n_bad++; $display("FAIL b2b_wren n=%0d got %b exp 1", n, memx_wren); end
                n_cmp++; if (mem0_idat !== wexp[n-1]) begin n_bad++; $display("FAIL b2b_data n=%0d got %h exp %h", n, mem0_idat, wexp[n-1]); end
                n_cmp++; if (memx_addr !== 32'h10 + 32'(n-1)) begin n_bad++; $display("FAIL b2b_addr n=%0d got %h exp %h", n, memx_addr, 32'h10 + 32'(n-1)); end
            end
        end
        i_vld = 1'b0;
        tick();
        n_cmp++; if (memx_wren !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_wren got %b exp 0", memx_wren); end
        n_cmp++; if (mem0_idat !== 32'h0C0B0A09) begin n_bad++; $display("FAIL b2b_hold got %h exp 0c0b0a09", mem0_idat); end
        n_cmp++; if (mem1_idat !== 32'h0) begin n_bad++; $display("FAIL b2b_k1 got %h exp 0", mem1_idat); end
        n_cmp++; if (o_wcnt !== 32'd3) begin n_bad++; $display("FAIL b2b_wcnt got %0d exp 3", o_wcnt); end
    endtask

    task automatic test_flush();
        logic [31:0] fexp [1:3];
        fexp = '{32'h00030201, 32'h00000605, 32'h00000009};
        for (int m = 1; m <= 3; m++) begin
            do_start(32'h20);
            for (int n = 0; n < m; n++) feed(k0(n));
            i_flush = 1'b1;
            tick();
            i_flush = 1'b0;
            n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL flush_rdy m=%0d got %b exp 0", m, o_rdy); end
            tick();
            n_cmp++; if (memx_wren !== 1'b1) begin n_bad++; $display("FAIL flush_wren m=%0d got %b exp 1", m, memx_wren); end
            n_cmp++; if (mem0_idat !== fexp[m]) begin n_bad++; $display("FAIL flush_data m=%0d got %h exp %h", m, mem0_idat, fexp[m]); end
            n_cmp++; if (memx_addr !== 32'h20 + 32'(m-1)) begin n_bad++; $display("FAIL flush_addr m=%0d got %h exp %h", m, memx_addr, 32'h20 + 32'(m-1)); end
            n_cmp++; if (o_rdy !== 1'b1 || o_done !== 1'b0) begin n_bad++; $display("FAIL flush_rdy_done m=%0d got rdy=%b done=%b exp rdy=1 done=0", m, o_rdy, o_done); end
            n_cmp++; if (o_wcnt !== 32'(m)) begin n_bad++; $display("FAIL flush_wcnt m=%0d got %0d exp %0d", m, o_wcnt, m); end
            tick();
            n_cmp++; if (o_done !== 1'b1 || memx_wren !== 1'b0) begin n_bad++; $display("FAIL flush_done m=%0d got done=%b wren=%b exp done=1 wren=0", m, o_done, memx_wren); end
            tick();
            n_cmp++; if (o_done !== 1'b0) begin n_bad++; $display("FAIL flush_done_pulse m=%0d got %b exp 0", m, o_done); end
        end
    endtask

    task automatic test_flush_phase0();
        do_start(32'h30);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL fp0_rdy got %b exp 0", o_rdy); end
        tick();
        n_cmp++; if (memx_wren !== 1'b0 || o_done !== 1'b0) begin n_bad++; $display("FAIL fp0_c1 got wren=%b done=%b exp 0 0", memx_wren, o_done); end
        tick();
        n_cmp++; if (memx_wren !== 1'b0 || o_done !== 1'b1) begin n_bad++; $display("FAIL fp0_c2 got wren=%b done=%b exp 0 1", memx_wren, o_done); end
        n_cmp++; if (o_wcnt !== 32'h0) begin n_bad++; $display("FAIL fp0_wcnt got %0d exp 0", o_wcnt); end
    endtask

    task automatic test_flush_with_vld();
        do_start(32'h40);
        for (int n = 0; n < 3; n++) feed(k0(n));
        i_vld   = 1'b1;
        i_flush = 1'b1;
        i_dat   = k0(3);
        tick();
        i_vld   = 1'b0;
        i_flush = 1'b0;
        n_cmp++; if (memx_wren !== 1'b1 || mem0_idat !== 32'h0C0B0A09 || memx_addr !== 32'h42) begin n_bad++; $display("FAIL fv_word got wren=%b data=%h addr=%h exp 1 0c0b0a09 42", memx_wren, mem0_idat, memx_addr); end
        n_cmp++; if (o_rdy !== 1'b0) begin n_bad++; $display("FAIL fv_rdy got %b exp 0", o_rdy); end
        tick();
        n_cmp++; if (memx_wren !== 1'b0) begin n_bad++; $display("FAIL fv_no_extra got %b exp 0", memx_wren); end
        tick();
        n_cmp++; if (o_done !== 1'b1) begin n_bad++; $display("FAIL fv_done got %b exp 1", o_done); end
        n_cmp++; if (o_wcnt !== 32'd3) begin n_bad++; $display("FAIL fv_wcnt got %0d exp 3", o_wcnt); end
    endtask

    task automatic test_all_kernels();
        int sent;
        int widx;
        logic [31:0] got [4];
        sent = 0;
        widx = 0;
        do_start(32'h100);
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent < 8 && (cyc >= 40 || $urandom_range(0, 2) != 0)) begin
                i_vld = 1'b1;
                i_dat = all_trip(sent);
                sent++;
            end else begin
                i_vld = 1'b0;
                i_dat = {$urandom, $urandom, $urandom};
            end
            tick();
            if (memx_wren === 1'b1) begin
                got = '{mem0_idat, mem1_idat, mem2_idat, mem3_idat};
                n_cmp++; if (memx_addr !== 32'h100 + 32'(widx)) begin n_bad++; $display("FAIL ak_addr w=%0d got %h exp %h", widx, memx_addr, 32'h100 + 32'(widx)); end
                for (int k = 0; k < 4; k++) begin
                    n_cmp++; if (got[k] !== all_word(k, widx)) begin n_bad++; $display("FAIL ak_data w=%0d k=%0d got %h exp %h", widx, k, got[k], all_word(k, widx)); end
                end
                widx++;
            end
        end
        i_vld = 1'b0;
        n_cmp++; if (widx != 6) begin n_bad++; $display("FAIL ak_count got %0d exp 6", widx); end
        n_cmp++; if (o_wcnt !== 32'd6) begin n_bad++; $display("FAIL ak_wcnt got %0d exp 6", o_wcnt); end
    endtask

    task automatic test_start_abort();
        do_start(32'h50);
        feed(k0(0));
        feed(k0(1));
        i_start     = 1'b1;
        i_base_addr = 32'h60;
        i_vld       = 1'b1;
        i_dat       = k0(2);
        tick();
        i_start = 1'b0;
        i_vld   = 1'b0;
        n_cmp++; if (memx_wren !== 1'b0 || o_wcnt !== 32'h0) begin n_bad++; $display("FAIL sa_start got wren=%b wcnt=%0d exp 0 0", memx_wren, o_wcnt); end
        feed(k0(0));
        feed(k0(1));
        n_cmp++; if (memx_wren !== 1'b1 || memx_addr !== 32'h60 || mem0_idat !== 32'h04030201) begin n_bad++; $display("FAIL sa_restart got wren=%b addr=%h data=%h exp 1 60 04030201", memx_wren, memx_addr, mem0_idat); end
        n_cmp++; if (o_wcnt !== 32'd1) begin n_bad++; $display("FAIL sa_wcnt got %0d exp 1", o_wcnt); end
        // Start during a pending flush cancels it entirely.
        do_start(32'h70);
        feed(k0(0));
        i_flush = 1'b1;
        tick();
        i_flush     = 1'b0;
        i_start     = 1'b1;
        i_base_addr = 32'h80;
        tick();
        i_start = 1'b0;
        n_cmp++; if (memx_wren !== 1'b0 || o_rdy !== 1'b1) begin n_bad++; $display("FAIL sa_flush_abort got wren=%b rdy=%b exp 0 1", memx_wren, o_rdy); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (o_done !== 1'b0 || memx_wren !== 1'b0) begin n_bad++; $display("FAIL sa_no_done c=%0d got done=%b wren=%b exp 0 0", c, o_done, memx_wren); end
        end
    endtask

    task automatic test_async_reset();
        do_start(32'h90);
        feed(k0(0));
        feed(k0(1));
        feed(k0(2));
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (memx_wren !== 1'b0 || memx_addr !== 32'h0 || o_wcnt !== 32'h0) begin n_bad++; $display("FAIL ar_ctrl got wren=%b addr=%h wcnt=%0d exp 0 0 0", memx_wren, memx_addr, o_wcnt); end
        n_cmp++; if ({mem0_idat, mem1_idat, mem2_idat, mem3_idat} !== 128'h0) begin n_bad++; $display("FAIL ar_idat got %h exp 0", mem0_idat); end
        #1;
        rst = 1'b0;
        feed(k0(0));
        n_cmp++; if (memx_wren !== 1'b0) begin n_bad++; $display("FAIL ar_no_partial got %b exp 0", memx_wren); end
        feed(k0(1));
        n_cmp++; if (memx_wren !== 1'b1 || memx_addr !== 32'h0 || mem0_idat !== 32'h04030201) begin n_bad++; $display("FAIL ar_resume got wren=%b addr=%h data=%h exp 1 0 04030201", memx_wren, memx_addr, mem0_idat); end
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        i_start     = 1'b0;
        i_base_addr = '0;
        i_dat       = '0;
        i_vld       = 1'b0;
        i_flush     = 1'b0;
        test_reset();
        test_back_to_back();
        test_flush();
        test_flush_phase0();
        test_flush_with_vld();
        test_all_kernels();
        test_start_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/weight_wr.md
WEIGHT_WR -- requirements
Module: weight_wr

Interface
REQ-001 Parameters SHALL be: MEM_DATA_WIDTH 32 (BRAM word width); MEM_ADDR_WIDTH 32 (BRAM address width); BIT_WIDTH 8 (weight width); NUM_CHANNEL 3 (weights per kernel triple); NUM_KERNEL 4 (kernel BRAMs); REG_WIDTH 32 (counter width); only these defaults are supported.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge
  rst  in  1  asynchronous active-high reset
  i_start  in  1  pulse: load i_base_addr, clear packing phase and word count
  i_base_addr  in  MEM_ADDR_WIDTH  first write address
  i_dat  in  96  kernel k triple at [24k+23:24k], weight j at [8j+7:8j] of the triple
  i_vld  in  1  i_dat valid
  o_rdy  out  1  block accepts i_dat / i_flush this cycle
  i_flush  in  1  pulse: write out residual partial word
  o_done  out  1  one-cycle pulse, flush complete
  o_wcnt  out  REG_WIDTH  words written since last start
  memx_addr  out  MEM_ADDR_WIDTH  shared write address, all four BRAMs
  memx_wren  out  1  shared write enable
  mem0_idat..mem3_idat  out  32 each  write data, kernel 0..3 BRAM

Function
REQ-003 Packing SHALL form a little-endian byte stream per kernel: triple n weight j is stream byte 3n+j; word w byte b is stream byte 4w+b, byte b at bits [8b+7:8b].
REQ-004 A triple SHALL be accepted on a rising edge where i_vld & o_rdy & ~i_start.
REQ-005 A 2-bit phase SHALL count accepted triples modulo 4 (0..3, wrap 3->0); residual bytes held: phase0 0, phase1 3, phase2 2, phase3 1.
REQ-006 Accepting a triple in phase 0 SHALL store it only; in phases 1, 2, 3 it SHALL complete one word (word0, word1, word2 of the 12-byte group) per kernel.
REQ-007 All memx_* and mem*_idat outputs SHALL be registered: a completed word SHALL present memx_wren=1 with its data and address in the cycle after acceptance, for exactly one cycle.
REQ-008 memx_addr SHALL equal the write address of the presented word; the internal address SHALL increment by 1 after each write and wrap modulo 2^MEM_ADDR_WIDTH.
REQ-009 o_wcnt SHALL increment by 1 per memx_wren cycle, wrapping at 2^REG_WIDTH.
REQ-010 FSM states SHALL be RUN and FLUSH; o_rdy SHALL be 1 in RUN, 0 in FLUSH.
REQ-011 i_flush & o_rdy SHALL move RUN->FLUSH; a triple offered in the same cycle SHALL be accepted first (phase update included).
REQ-012 In FLUSH, if residual>0, the residual bytes SHALL be written zero-padded in upper bytes (memx_wren=1 next cycle, address increments); if residual=0, no write; phase SHALL clear to 0; state SHALL return to RUN; o_done SHALL be 1 in the following cycle.
REQ-013 i_start SHALL take priority over i_vld and i_flush: next cycle address=i_base_addr, phase=0, residual discarded, o_wcnt=0, state RUN, memx_wren=0; asserting it during FLUSH SHALL abort the flush with no write and no o_done.
REQ-014 memx_wren SHALL be 0 in any cycle without a completed or flushed word; mem*_idat SHALL hold the last written value when memx_wren=0.

Reset
REQ-015 rst=1 SHALL immediately force: state RUN, phase 0, residual 0, address 0, o_wcnt 0, memx_addr 0, memx_wren 0, mem0..3_idat 0, o_done 0; o_rdy 1 after deassertion.
REQ-016 Reset mid-stream or mid-flush SHALL discard all residual data with no partial write.

Verification
REQ-017 Start base 0x10; kernel 0 triples 0x030201, 0x060504, 0x090807, 0x0C0B0A back-to-back -> mem0_idat 0x04030201, 0x08070605, 0x0C0B0A09 at memx_addr 0x10, 0x11, 0x12, each one cycle after the 2nd/3rd/4th acceptance; o_wcnt=3.
REQ-018 Flush after 1, 2, 3 triples (above data) -> flushed words 0x00030201, 0x00000605, 0x00000009 respectively; o_done one cycle after the flush write; o_rdy=0 for one cycle.
REQ-019 Flush with phase 0 -> no memx_wren, o_done pulses two cycles after i_flush accepted; flush with i_vld same cycle in phase 3 -> normal word write, no extra flush write, o_done pulses.
REQ-020 Distinct data on all four kernels, 8 triples with random i_vld gaps -> 6 writes, each memN_idat matching its own kernel stream; addresses consecutive.
REQ-021 i_start asserted with i_vld in phase 2 -> triple ignored, next write at new base, o_wcnt restarts at 0; async rst asserted mid-cycle -> all outputs 0 before next clock edge.
